// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes,
// FSM state type and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: legality/alignment checks, byte enables,
// store data replication and load data shift with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    be,
  output logic [XLEN-1:0]  wdata_lane,
  output logic [XLEN-1:0]  rdata_ext,
  output logic             legal,
  output logic             aligned
);

  logic [NB-1:0]    be_base;
  logic [XLEN-1:0]  keep;
  logic [XLEN-1:0]  rshift;
  logic             sign_bit;
  logic [OFF_W-1:0] align_mask;

  always_comb begin
    legal = 1'b0;
    if (we) begin
      case (funct3)
        SB, SH, SW: legal = 1'b1;
        SD:         legal = (XLEN == 64);
        default:    legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        LB, LH, LW, LBU, LHU: legal = 1'b1;
        LD, LWU:              legal = (XLEN == 64);
        default:              legal = 1'b0;
      endcase
    end
  end

  assign align_mask = OFF_W'(size_bytes(funct3) - 4'd1);
  assign aligned    = (offset & align_mask) == '0;

  // Replicating the store datum across the word puts it in every lane the
  // byte enables can select, so no shifter is needed on the write path.
  always_comb begin
    be_base    = '1;
    keep       = '1;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'd0: begin
        be_base    = NB'(1);
        keep       = XLEN'(8'hFF);
        wdata_lane = {NB{wdata[7:0]}};
      end
      2'd1: begin
        be_base    = NB'(2'b11);
        keep       = XLEN'(16'hFFFF);
        wdata_lane = {(NB/2){wdata[15:0]}};
      end
      2'd2: begin
        be_base    = NB'(4'hF);
        keep       = XLEN'(32'hFFFF_FFFF);
        wdata_lane = {(NB/4){wdata[31:0]}};
      end
      default: begin
        be_base    = '1;
        keep       = '1;
        wdata_lane = wdata;
      end
    endcase
  end

  assign be        = be_base << offset;
  assign rshift    = rdata >> {offset, 3'b000};
  // keep ^ (keep >> 1) isolates the top bit of the access.
  assign sign_bit  = |(rshift & (keep ^ (keep >> 1)));
  assign rdata_ext = (rshift & keep) | ((!funct3[2] && sign_bit) ? ~keep : '0);

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core data path and the MMIO bus:
// request/grant/response handshake, core stall and error reporting.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic [XLEN-1:0]   core_rdata,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_e        state, state_n;
  logic              we_r, err_r;
  logic [2:0]        f3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [XLEN-1:0]   wdata_r, rdata_r;
  logic [CNT_W-1:0]  cnt;

  logic              sel_core, we_m;
  logic [2:0]        f3_m;
  logic [ADDR_W-1:0] addr_m;
  logic [XLEN-1:0]   wdata_m;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata_lane, rdata_ext;
  logic              legal, aligned, to_hit, resp;

  // In IDLE the checks look at the live core request; afterwards at the latched copy.
  assign sel_core = (state == IDLE);
  assign we_m     = sel_core ? core_we     : we_r;
  assign f3_m     = sel_core ? core_funct3 : f3_r;
  assign addr_m   = sel_core ? core_addr   : addr_r;
  assign wdata_m  = sel_core ? core_wdata  : wdata_r;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .we        (we_m),
    .funct3    (f3_m),
    .offset    (addr_m[OFF_W-1:0]),
    .wdata     (wdata_m),
    .rdata     (rdata_r),
    .be        (be),
    .wdata_lane(wdata_lane),
    .rdata_ext (rdata_ext),
    .legal     (legal),
    .aligned   (aligned)
  );

  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign resp   = bus_rvalid && ((state == WAIT) || ((state == REQ) && bus_gnt));

  // A response in hand wins over a timeout expiring in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (core_req) state_n = (legal && aligned) ? REQ : DONE;
      REQ: begin
        if (resp || to_hit) state_n = DONE;
        else if (bus_gnt)   state_n = WAIT;
      end
      WAIT: if (resp || to_hit) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      f3_r    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (core_req) begin
            we_r    <= core_we;
            f3_r    <= core_funct3;
            addr_r  <= core_addr;
            wdata_r <= core_wdata;
            rdata_r <= '0;
            err_r   <= !(legal && aligned);
          end
        end
        REQ, WAIT: begin
          cnt <= cnt + 1'b1;
          if (resp) begin
            rdata_r <= bus_rdata;
            err_r   <= bus_err;
          end else if (to_hit) begin
            err_r <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_be     = '0;
    bus_wdata  = '0;
    core_done  = 1'b0;
    core_err   = 1'b0;
    core_rdata = '0;
    if (state == REQ) begin
      bus_req   = 1'b1;
      bus_we    = we_r;
      bus_addr  = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      bus_be    = be;
      bus_wdata = wdata_lane;
    end
    if (state == DONE) begin
      core_done  = 1'b1;
      core_err   = err_r;
      core_rdata = (err_r || we_r) ? '0 : rdata_ext;
    end
  end

  assign core_stall = core_req & ~core_done;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: a 32-bit instance with a short
// timeout and a 64-bit instance with the timeout disabled.
module tb_lsu_bus_bridge;

  localparam int TO_A = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, we, gnt, rvalid, berr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, bus_rdata;

  logic        stall_a, done_a, err_a, breq_a, bwe_a;
  logic [31:0] rdata_a, baddr_a, bwd_a;
  logic [3:0]  be_a;
  logic        stall_b, done_b, err_b, breq_b, bwe_b;
  logic [63:0] rdata_b, bwd_b;
  logic [31:0] baddr_b;
  logic [7:0]  be_b;

  logic        o_stall, o_done, o_err, o_breq, o_bwe;
  logic [63:0] o_rdata, o_bwd;
  logic [31:0] o_baddr;
  logic [7:0]  o_be;
  bit          sel64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .core_req(req_a), .core_we(we), .core_funct3(f3),
    .core_addr(addr), .core_wdata(wdata[31:0]), .core_stall(stall_a),
    .core_done(done_a), .core_err(err_a), .core_rdata(rdata_a),
    .bus_req(breq_a), .bus_gnt(gnt), .bus_we(bwe_a), .bus_addr(baddr_a),
    .bus_be(be_a), .bus_wdata(bwd_a), .bus_rvalid(rvalid),
    .bus_rdata(bus_rdata[31:0]), .bus_err(berr)
  );

  lsu_bus_bridge #(.XLEN(64), .ADDR_W(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .core_req(req_b), .core_we(we), .core_funct3(f3),
    .core_addr(addr), .core_wdata(wdata), .core_stall(stall_b),
    .core_done(done_b), .core_err(err_b), .core_rdata(rdata_b),
    .bus_req(breq_b), .bus_gnt(gnt), .bus_we(bwe_b), .bus_addr(baddr_b),
    .bus_be(be_b), .bus_wdata(bwd_b), .bus_rvalid(rvalid),
    .bus_rdata(bus_rdata), .bus_err(berr)
  );

  always_comb begin
    if (sel64) begin
      o_stall = stall_b; o_done = done_b; o_err = err_b; o_breq = breq_b;
      o_bwe = bwe_b; o_rdata = rdata_b; o_bwd = bwd_b; o_baddr = baddr_b; o_be = be_b;
    end else begin
      o_stall = stall_a; o_done = done_a; o_err = err_a; o_breq = breq_a;
      o_bwe = bwe_a; o_rdata = {32'h0, rdata_a}; o_bwd = {32'h0, bwd_a};
      o_baddr = baddr_a; o_be = {4'h0, be_a};
    end
  end

  // Size/direction legality straight from the ISA table.
  function automatic bit m_legal(input bit w64, input bit st, input logic [2:0] code);
    int c;
    c = int'(code);
    if (st) return (c <= 2) || (c == 3 && w64);
    return (c <= 2) || c == 4 || c == 5 || ((c == 3 || c == 6) && w64);
  endfunction

  // Drives one core access with a scripted bus responder and checks every cycle.
  task automatic do_txn(input bit w64, input bit t_we, input logic [2:0] t_f3,
                        input logic [31:0] t_addr, input logic [63:0] t_wd,
                        input logic [63:0] t_rd, input bit t_berr,
                        input int gnt_dly, input int rv_dly,
                        output logic [63:0] got_rdata, output logic [7:0] got_be,
                        output int got_done_c, output logic got_err);
    int nb, sz, off, to, gnt_c, rv_c, done_exp, req_last;
    bit ok, timed_out, exp_err;
    logic [63:0] exp_rd, mask, rd_m, wd_m;
    logic [7:0]  exp_be;
    logic [31:0] exp_baddr;
    nb   = w64 ? 8 : 4;
    sz   = 1 << t_f3[1:0];
    off  = int'(t_addr[2:0]) % nb;
    rd_m = w64 ? t_rd : {32'h0, t_rd[31:0]};
    wd_m = w64 ? t_wd : {32'h0, t_wd[31:0]};
    ok   = m_legal(w64, t_we, t_f3) && (off % sz == 0);
    to   = w64 ? 0 : TO_A;
    if (!ok) begin
      gnt_c = 1000; rv_c = 1000; done_exp = 1; req_last = 0;
      timed_out = 1'b0; exp_err = 1'b1;
    end else begin
      gnt_c     = 1 + gnt_dly;
      rv_c      = gnt_c + rv_dly;
      timed_out = (to != 0) && (rv_c > to);
      done_exp  = timed_out ? to + 1 : rv_c + 1;
      req_last  = timed_out ? ((gnt_c < to) ? gnt_c : to) : gnt_c;
      exp_err   = timed_out || t_berr;
    end
    mask   = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    exp_rd = (rd_m >> (8 * off)) & mask;
    if (!t_f3[2] && (((exp_rd >> (8 * sz - 1)) & 64'd1) != 64'd0)) exp_rd = exp_rd | ~mask;
    if (!w64) exp_rd = exp_rd & 64'hFFFF_FFFF;
    if (exp_err || t_we) exp_rd = '0;
    exp_be    = 8'(((1 << sz) - 1) << off);
    exp_baddr = t_addr - 32'(off);

    sel64 = w64; got_done_c = -1; got_be = '0; got_rdata = '0; got_err = 1'b0;
    for (int c = 0; c <= done_exp + 3; c++) begin
      bit rq, ebreq, edone, spur;
      rq    = (c <= done_exp);
      spur  = (c == done_exp + 2);
      req_a = rq && !w64;
      req_b = rq && w64;
      we = t_we; f3 = t_f3; addr = t_addr; wdata = t_wd;
      gnt       = (c == gnt_c && rq) || spur;
      rvalid    = (c == rv_c && rq) || spur;
      bus_rdata = spur ? {$urandom, $urandom} : t_rd;
      berr      = spur ? 1'b1 : t_berr;
      @(negedge clk);
      ebreq = (c >= 1) && (c <= req_last);
      edone = (c == done_exp);
      n_tests++;
      if (o_breq !== ebreq) begin
        n_fail++; $display("FAIL bus_req c=%0d got=%b exp=%b", c, o_breq, ebreq);
      end
      n_tests++;
      if (o_done !== edone) begin
        n_fail++; $display("FAIL core_done c=%0d got=%b exp=%b", c, o_done, edone);
      end
      n_tests++;
      if (o_stall !== (rq && !edone)) begin
        n_fail++; $display("FAIL core_stall c=%0d got=%b exp=%b", c, o_stall, rq && !edone);
      end
      if (o_done === 1'b1 && got_done_c < 0) begin
        got_done_c = c; got_rdata = o_rdata; got_err = o_err;
      end
      if (ebreq) begin
        got_be = o_be;
        n_tests++;
        if (o_bwe !== t_we || o_baddr !== exp_baddr || o_be !== exp_be) begin
          n_fail++;
          $display("FAIL bus_ctrl c=%0d got we=%b addr=%h be=%h exp we=%b addr=%h be=%h",
                   c, o_bwe, o_baddr, o_be, t_we, exp_baddr, exp_be);
        end
        if (t_we) begin
          for (int j = 0; j < nb; j++) begin
            logic [7:0] eb, gb;
            if (((exp_be >> j) & 8'd1) != 8'd0) begin
              eb = 8'(wd_m >> (8 * (j - off)));
              gb = 8'(o_bwd >> (8 * j));
              n_tests++;
              if (gb !== eb) begin
                n_fail++; $display("FAIL bus_wdata lane%0d got=%h exp=%h", j, gb, eb);
              end
            end
          end
        end
      end
      if (edone) begin
        n_tests++;
        if (o_err !== exp_err || o_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL result f3=%0d addr=%h got err=%b rdata=%h exp err=%b rdata=%h",
                   t_f3, t_addr, o_err, o_rdata, exp_err, exp_rd);
        end
      end
      @(posedge clk); #1;
    end
    req_a = 1'b0; req_b = 1'b0; gnt = 1'b0; rvalid = 1'b0; berr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; we = 1'b0; f3 = 3'b010; addr = 32'h100;
    wdata = '0; bus_rdata = '0; gnt = 1'b1; rvalid = 1'b1; berr = 1'b0; sel64 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({done_a, err_a, rdata_a, breq_a, bwe_a, baddr_a, be_a, bwd_a} !== '0) begin
        n_fail++; $display("FAIL reset_a got done=%b req=%b be=%h", done_a, breq_a, be_a);
      end
      n_tests++;
      if ({stall_b, done_b, err_b, rdata_b, breq_b, bwe_b, baddr_b, be_b, bwd_b} !== '0) begin
        n_fail++; $display("FAIL reset_b got done=%b req=%b be=%h", done_b, breq_b, be_b);
      end
    end
    @(posedge clk); #1;
    req_a = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_sign();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    do_txn(0, 0, 3'b000, 32'h103, 64'h0, 64'h80AB_CD12, 0, 0, 2, r, b, dc, e);
    n_tests++;
    if (r !== 64'hFFFF_FF80 || b !== 8'h08 || dc !== 4 || e !== 1'b0) begin
      n_fail++; $display("FAIL lb_sign got rdata=%h be=%h done_c=%0d err=%b exp FFFFFF80 08 4 0", r, b, dc, e);
    end
  endtask

  task automatic test_store_half();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    do_txn(0, 1, 3'b001, 32'h202, 64'h0000_BEEF, 64'h1234_5678, 0, 1, 1, r, b, dc, e);
    n_tests++;
    if (b !== 8'h0C || dc !== 4 || e !== 1'b0 || r !== 64'h0) begin
      n_fail++; $display("FAIL sh got be=%h done_c=%0d err=%b rdata=%h exp 0c 4 0 0", b, dc, e, r);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    do_txn(0, 0, 3'b010, 32'h101, 64'h0, 64'hFFFF_FFFF, 0, 0, 0, r, b, dc, e);
    n_tests++;
    if (dc !== 1 || e !== 1'b1 || r !== 64'h0) begin
      n_fail++; $display("FAIL lw_misaligned got done_c=%0d err=%b rdata=%h exp 1 1 0", dc, e, r);
    end
    do_txn(0, 0, 3'b011, 32'h100, 64'h0, 64'h5, 0, 0, 0, r, b, dc, e);
    n_tests++;
    if (dc !== 1 || e !== 1'b1) begin
      n_fail++; $display("FAIL ld_on_rv32 got done_c=%0d err=%b exp 1 1", dc, e);
    end
    do_txn(1, 1, 3'b100, 32'h100, 64'h0, 64'h5, 0, 0, 0, r, b, dc, e);
    n_tests++;
    if (dc !== 1 || e !== 1'b1) begin
      n_fail++; $display("FAIL store_f3_100 got done_c=%0d err=%b exp 1 1", dc, e);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    do_txn(0, 0, 3'b010, 32'h100, 64'h0, 64'h7, 0, 10, 0, r, b, dc, e);
    n_tests++;
    if (dc !== 5 || e !== 1'b1 || r !== 64'h0) begin
      n_fail++; $display("FAIL timeout_nognt got done_c=%0d err=%b rdata=%h exp 5 1 0", dc, e, r);
    end
    do_txn(0, 0, 3'b010, 32'h100, 64'h0, 64'h7, 0, 1, 5, r, b, dc, e);
    n_tests++;
    if (dc !== 5 || e !== 1'b1) begin
      n_fail++; $display("FAIL timeout_norvalid got done_c=%0d err=%b exp 5 1", dc, e);
    end
    do_txn(1, 0, 3'b011, 32'h108, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0, 12, 3, r, b, dc, e);
    n_tests++;
    if (dc !== 17 || e !== 1'b0 || r !== 64'hDEAD_BEEF_0BAD_F00D) begin
      n_fail++; $display("FAIL no_timeout64 got done_c=%0d err=%b rdata=%h", dc, e, r);
    end
  endtask

  task automatic test_lwu64();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    do_txn(1, 0, 3'b110, 32'h14, 64'h0, 64'h8000_0001_1234_5678, 0, 0, 1, r, b, dc, e);
    n_tests++;
    if (r !== 64'h0000_0000_8000_0001 || b !== 8'hF0 || e !== 1'b0) begin
      n_fail++; $display("FAIL lwu64 got rdata=%h be=%h err=%b exp 0000000080000001 f0 0", r, b, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    sel64 = 1'b0; req_a = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    n_tests++;
    if (breq_a !== 1'b0 || stall_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL wait_state got req=%b stall=%b done=%b exp 0 1 0", breq_a, stall_a, done_a);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; bus_rdata = 64'h1111_2222;
    @(negedge clk);
    n_tests++;
    if ({stall_a, done_a, err_a, rdata_a, breq_a, bwe_a, baddr_a, be_a, bwd_a} !== '0) begin
      n_fail++; $display("FAIL reset_mid got done=%b req=%b rdata=%h exp all zero", done_a, breq_a, rdata_a);
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (done_a !== 1'b0 || breq_a !== 1'b0) begin
        n_fail++; $display("FAIL after_reset got done=%b req=%b exp 0 0", done_a, breq_a);
      end
      @(posedge clk); #1;
    end
    do_txn(0, 0, 3'b101, 32'h42, 64'h0, 64'h8123_4567, 0, 0, 0, r, b, dc, e);
    n_tests++;
    if (dc !== 2 || e !== 1'b0 || r !== 64'h0000_8123) begin
      n_fail++; $display("FAIL fresh_txn got done_c=%0d err=%b rdata=%h exp 2 0 8123", dc, e, r);
    end
  endtask

  task automatic test_random();
    logic [63:0] r; logic [7:0] b; int dc; logic e;
    for (int n = 0; n < 60; n++) begin
      bit w64, st, be_err;
      logic [2:0]  code;
      logic [31:0] a;
      int sz;
      w64    = 1'($urandom_range(0, 1));
      st     = 1'($urandom_range(0, 1));
      code   = 3'($urandom_range(0, 7));
      a      = $urandom;
      sz     = 1 << code[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      be_err = ($urandom_range(0, 7) == 0);
      do_txn(w64, st, code, a, {$urandom, $urandom}, {$urandom, $urandom}, be_err,
             $urandom_range(0, 3), $urandom_range(0, 3), r, b, dc, e);
    end
  endtask

  initial begin
    test_reset();
    test_load_sign();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_lwu64();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Parametrised load/store unit between the single-cycle core's data path and the memory/UART MMIO bus.
- Replaces the raw combinational tristate data port with a registered request/grant/response handshake.
- Generates byte enables and data lane steering from funct3, and sign/zero-extends load data.
- Stalls the core while a transaction is outstanding; flags misaligned accesses, illegal sizes, bus errors and timeouts.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum cycles from request to response before an error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  core presents a load/store this cycle; held until core_done
- core_we  in  1  1 = store, 0 = load
- core_funct3  in  3  RISC-V size/sign code
- core_addr  in  ADDR_W  byte address (ALU Result)
- core_wdata  in  XLEN  store data (rs2)
- core_stall  out  1  freeze PC and register write
- core_done  out  1  one-cycle completion pulse
- core_err  out  1  valid with core_done; access failed
- core_rdata  out  XLEN  extended load data, valid with core_done
- bus_req  out  1  bus request
- bus_gnt  in  1  bus accepted the request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  address aligned down to XLEN/8 bytes
- bus_be  out  XLEN/8  byte enables
- bus_wdata  out  XLEN  lane-shifted store data
- bus_rvalid  in  1  response (read data or write acknowledge)
- bus_rdata  in  XLEN  read data
- bus_err  in  1  error qualifier, valid with bus_rvalid

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On core_req, latch we, funct3, addr and wdata.
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with err=1 and no bus activity.
- Legal sizes:
  - funct3 000/100 (byte), 001/101 (half), 010 (word).
  - With XLEN=64, also 011 (double) and 110 (LWU).
  - Stores accept only 000/001/010, plus 011 when XLEN=64.
  - All other codes are illegal.
- Alignment: address offset must be a multiple of the access size.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata come from the latched registers and are stable until bus_gnt.
  - On bus_gnt, go to WAIT.
  - bus_gnt and bus_rvalid in the same cycle: go straight to DONE.
- WAIT:
  - bus_req=0.
  - On bus_rvalid, capture bus_rdata and bus_err, then go to DONE.
- DONE:
  - core_done=1 for exactly one cycle; core_err is the recorded error.
  - core_rdata = selected lane shifted down, sign-extended for 000/001/010 and zero-extended for 100/101/110.
  - core_rdata = 0 for stores and on error.
  - Return to IDLE. A new core_req is not sampled in DONE.
- bus_be: a contiguous mask of size bytes, shifted left by the byte offset.
- bus_wdata: core_wdata left-shifted by 8×offset; unused lanes carry don't-care data, driven as replicated bytes.
- Stall: core_stall = core_req & ~core_done (combinational). The core advances on the cycle core_done is high.
- Timeout:
  - The counter clears on leaving IDLE and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT, go to DONE with err=1 and drop bus_req.
  - A late bus_rvalid is then ignored.
- Spurious responses: bus_rvalid or bus_gnt arriving in IDLE or DONE are ignored.
- Reset mid-transaction: state returns to IDLE on the next edge and bus_req deasserts. The bus owner must tolerate the abandoned transaction.
- Latency: minimum 2 cycles from core_req to core_done (gnt+rvalid together in REQ); misaligned or illegal accesses take 1 cycle.
- Ordering: at most one transaction outstanding.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 size/sign constants (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD);
  - the state enum lsu_state_e;
  - helper function size_bytes(funct3).
- Sub-module lsu_lane_align (combinational):
  - byte-enable generation, store shift, load shift/extend;
  - legal/aligned checks.
- The FSM and timeout counter live in lsu_bus_bridge.

Test Plan:
1. XLEN=32: load, funct3=000, addr=0x103; bus returns rdata=0x80AB_CD12 with gnt in cycle 1 and rvalid in cycle 3.
   Required: bus_addr=0x100, bus_be=4'b1000, core_rdata=0xFFFF_FF80, err=0, done in cycle 4, stall high in cycles 0–3.
2. Store, funct3=001, addr=0x202, wdata=0x0000_BEEF.
   Required: bus_be=4'b1100, bus_wdata[31:16]=0xBEEF, bus_we=1; after rvalid, done=1, err=0.
3. Load, funct3=010, addr=0x101.
   Required: no bus_req ever asserted; done=1, err=1, rdata=0 one cycle after req.
4. TIMEOUT=4; gnt never asserted.
   Required: bus_req high for 4 cycles then low; done=1, err=1. An rvalid injected later is ignored and state stays IDLE.
5. XLEN=64: funct3=110, addr=0x14; rdata lane[63:32]=0x8000_0001.
   Required: core_rdata=0x0000_0000_8000_0001, bus_be=8'hF0.
6. rst asserted in WAIT.
   Required: next cycle all outputs 0; a subsequent rvalid yields no done; a fresh request then completes normally.
